// File: rtl/camera_config_seq_pkg.sv
// Shared types and constants for the camera register configuration sequencer.
package camera_config_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DELAY,
    ST_FINISH
  } cam_state_e;

  localparam logic [7:0]  CAM_DELAY_ADDR = 8'hF0;
  localparam logic [15:0] CAM_END_ENTRY  = 16'hFFFF;
  localparam logic [15:0] COM7_RESET     = {8'h12, 8'h80};

  function automatic logic [15:0] cam_entry(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/camera_config_seq_if.sv
// Write-request handshake between the configuration sequencer and an SCCB master.
interface camera_config_seq_if;

  logic       sccb_start;
  logic [7:0] sccb_address;
  logic [7:0] sccb_data;
  logic       sccb_ready;

  modport master (
    output sccb_start,
    output sccb_address,
    output sccb_data,
    input  sccb_ready
  );

  modport slave (
    input  sccb_start,
    input  sccb_address,
    input  sccb_data,
    output sccb_ready
  );

endinterface

// File: rtl/ov7670_reg_rom.sv
// OV7670 register table: {addr,data} entries, one-cycle registered read.
module ov7670_reg_rom
  import camera_config_seq_pkg::*;
#(
  parameter int ROM_AW = 6
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [15:0]       entry_o
);

  localparam int DEPTH = 2 ** ROM_AW;

  // addr 0xF0 entries are millisecond delays; 0xFFFF terminates the table
  function automatic logic [15:0] rom_entry(input int unsigned idx);
    case (idx)
      0:       return COM7_RESET;
      1:       return cam_entry(CAM_DELAY_ADDR, 8'h0A);
      2:       return cam_entry(8'h12, 8'h04);
      3:       return cam_entry(8'h11, 8'h01);
      4:       return cam_entry(8'h0C, 8'h00);
      5:       return cam_entry(8'h3E, 8'h00);
      6:       return cam_entry(8'h40, 8'hD0);
      7:       return cam_entry(8'h3A, 8'h04);
      8:       return cam_entry(8'h17, 8'h13);
      9:       return cam_entry(8'h18, 8'h01);
      10:      return cam_entry(CAM_DELAY_ADDR, 8'h00);
      11:      return cam_entry(8'h32, 8'hB6);
      default: return CAM_END_ENTRY;
    endcase
  endfunction

  logic [15:0] table_w [DEPTH];
  logic [15:0] entry_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
    assign table_w[gi] = rom_entry(gi);
  end

  always_ff @(posedge clk) begin
    entry_q <= table_w[addr_i];
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/camera_config_seq.sv
// Walks the OV7670 register table and issues one SCCB write per entry.
// Define CFG_DELAY_EN to execute addr-0xF0 entries as millisecond delays.
module camera_config_seq
  import camera_config_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 27000000,
  parameter int          ROM_AW   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  camera_config_seq_if.master  sccb,
  output logic                 busy,
  output logic                 done,
  output logic [ROM_AW-1:0]    entry_idx
);

  if (CLK_FREQ < 1000) begin : g_clk_freq_check
    $error("CLK_FREQ must be at least 1000 Hz");
  end

  cam_state_e        state_q;
  logic [ROM_AW-1:0] idx_q, idx_d;
  logic              start_q, busy_q, done_q;
  logic [7:0]        addr_q, data_q;
  logic [15:0]       rom_entry_w;
  logic              is_end_w, is_delay_w, last_w, adv_w;

`ifdef CFG_DELAY_EN
  localparam logic [31:0] TICKS_PER_MS = 32'(CLK_FREQ / 1000);
  logic [31:0] tick_q;
  logic [31:0] ms_q;
  logic [7:0]  ms_target_q;
  logic        delay_done_w;

  assign delay_done_w = (ms_q == {24'd0, ms_target_q});
`endif

  assign is_end_w   = (rom_entry_w == CAM_END_ENTRY);
  assign is_delay_w = (rom_entry_w[15:8] == CAM_DELAY_ADDR);
  assign last_w     = &idx_q;

  always_comb begin
    adv_w = 1'b0;
    case (state_q)
`ifndef CFG_DELAY_EN
      ST_FETCH:     adv_w = is_delay_w;
`else
      ST_DELAY:     adv_w = delay_done_w;
`endif
      ST_WAIT_HIGH: adv_w = sccb.sccb_ready;
      default:      adv_w = 1'b0;
    endcase
  end

  // The ROM is addressed with the next index so FETCH sees valid data immediately
  always_comb begin
    idx_d = idx_q;
    if (!rst_n) begin
      idx_d = '0;
    end else if (state_q == ST_IDLE && cfg_start) begin
      idx_d = '0;
    end else if (adv_w && !last_w) begin
      idx_d = idx_q + 1'b1;
    end
  end

  ov7670_reg_rom #(
    .ROM_AW (ROM_AW)
  ) u_rom (
    .clk     (clk),
    .addr_i  (idx_d),
    .entry_o (rom_entry_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CFG_DELAY_EN
      tick_q      <= 32'd0;
      ms_q        <= 32'd0;
      ms_target_q <= 8'd0;
`endif
    end else begin
      idx_q <= idx_d;
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (is_end_w) begin
            state_q <= ST_FINISH;
          end else if (is_delay_w) begin
`ifdef CFG_DELAY_EN
            ms_target_q <= rom_entry_w[7:0];
            tick_q      <= 32'd0;
            ms_q        <= 32'd0;
            state_q     <= ST_DELAY;
`else
            state_q <= last_w ? ST_FINISH : ST_FETCH;
`endif
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sccb.sccb_ready) begin
            addr_q  <= rom_entry_w[15:8];
            data_q  <= rom_entry_w[7:0];
            start_q <= 1'b1;
            state_q <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!sccb.sccb_ready) begin
            start_q <= 1'b0;
            state_q <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (sccb.sccb_ready) begin
            state_q <= last_w ? ST_FINISH : ST_FETCH;
          end
        end
        ST_DELAY: begin
`ifdef CFG_DELAY_EN
          if (delay_done_w) begin
            state_q <= last_w ? ST_FINISH : ST_FETCH;
          end else if (tick_q == TICKS_PER_MS - 32'd1) begin
            tick_q <= 32'd0;
            ms_q   <= ms_q + 32'd1;
          end else begin
            tick_q <= tick_q + 32'd1;
          end
`else
          state_q <= ST_FINISH;
`endif
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sccb.sccb_start   = start_q;
  assign sccb.sccb_address = addr_q;
  assign sccb.sccb_data    = data_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign entry_idx         = idx_q;

endmodule
